btle_rx_pdu_reader: RTL
=======================

Name: btle_rx_pdu_reader

Overview:
- Sits on the far side of the PHY receive PDU memory and reads out what the receiver wrote.
- Each `rx_decode_end` pulse starts a walk of the PDU octet memory from address 0. The block streams header plus payload octets over a valid/ready octet stream toward the link-layer/host side.
- It also reports per-packet status: CRC, best phase, truncation and dropped packets.

Parameters:
- MEM_ADDR_BIT_WIDTH, 6: PDU octet memory address width. Capacity is 2^MEM_ADDR_BIT_WIDTH octets (64).
- DROP_BAD_CRC, 0: 1 = packets with `rx_crc_ok`=0 are discarded without streaming.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- rx_decode_end  in  1  one-cycle pulse: packet in memory complete
- rx_decode_run  in  1  receiver currently writing memory
- rx_crc_ok  in  1  valid with rx_decode_end
- rx_best_phase  in  3  valid with rx_decode_end
- rx_payload_length  in  7  payload octets, excludes the 2 header octets; valid with rx_decode_end
- pdu_octet_mem_addr  out  MEM_ADDR_BIT_WIDTH  read address to PDU memory
- pdu_octet_mem_data  in  8  read data, valid exactly 1 cycle after the address is driven
- m_octet  out  8  stream data
- m_valid  out  1  stream valid
- m_last  out  1  final beat of packet
- m_ready  in  1  sink ready
- pkt_crc_ok  out  1  latched CRC status of current/last packet
- pkt_best_phase  out  3  latched best phase
- pkt_truncated  out  1  latched: packet longer than memory
- pkt_overrun  out  1  sticky: rx_decode_run seen while reading
- busy  out  1  state != IDLE
- drop_cnt  out  8  saturating count of discarded packets

Behaviour:
- Reset (rst=0 at a clk edge), all outputs 0, state IDLE:
  - m_octet, m_valid, m_last, pdu_octet_mem_addr, pkt_* , busy and drop_cnt all 0.
  - Reset mid-stream aborts immediately; no further beats are produced.
- Memory layout: address 0 = header octet 0, address 1 = header octet 1 (length), addresses 2.. = payload. CRC octets are not read.
- Length arithmetic:
  - total = rx_payload_length + 2, computed 8-bit.
  - If total > 2^MEM_ADDR_BIT_WIDTH: clamp to 2^MEM_ADDR_BIT_WIDTH and set pkt_truncated=1, else 0.
  - Last address = total-1.
- FSM states IDLE, FETCH, WAIT, SEND, STATUS (STATUS exists only with the optional feature).
- IDLE, rx_decode_end=1 at cycle T:
  - Latch crc_ok, best_phase, total and truncated.
  - Clear pkt_overrun; set addr=0.
  - If DROP_BAD_CRC=1 and rx_crc_ok=0: drop_cnt += 1 (saturate at 255) and stay in IDLE.
  - Otherwise go to FETCH.
- FETCH (T+1): pdu_octet_mem_addr holds the current address → WAIT.
- WAIT (T+2): pdu_octet_mem_data is captured into m_octet at the clock edge. m_last = (addr == total-1). → SEND.
- SEND (from T+3):
  - m_valid=1; m_octet and m_last are stable until m_valid && m_ready.
  - On handshake, if not last: addr+1 → FETCH.
  - On handshake, if last: → STATUS (feature on) or IDLE (feature off).
  - m_valid deasserts the cycle after the handshake.
- Throughput: one octet per 3 cycles with m_ready held 1. First m_valid arrives 3 cycles after rx_decode_end.
- rx_decode_end while busy=1: the packet is ignored (no relatch), drop_cnt += 1 saturating, and the current stream continues unchanged.
- rx_decode_run=1 while busy=1: pkt_overrun=1, held until the next accepted packet. The stream continues, since data may be corrupt.
- Address never exceeds 2^MEM_ADDR_BIT_WIDTH-1; no wrap-around.

Optional Feature:
- Macro BTLE_RX_PDU_STATUS_BEAT_EN.
- Defined: after the last memory octet is handshaken (m_last=0 on that beat), the FSM enters STATUS. It emits one extra beat with m_valid=1 and m_last=1:
  - m_octet = {pkt_crc_ok, pkt_truncated, pkt_overrun, 2'b00, pkt_best_phase}.
  - The beat is held until m_ready, then the FSM returns to IDLE.
- Undefined: no STATUS state; m_last marks the last memory octet and status is available only on the pkt_* ports.

Test Plan:
- Length 5, crc_ok=1, phase=3, m_ready=1, memory 0x40,0x05,0x11..0x15:
  - 7 beats 0x40,0x05,0x11..0x15 on addresses 0..6.
  - First m_valid at T+3, one beat per 3 cycles, m_last on 0x15.
  - pkt_best_phase=3.
- Same packet with m_ready toggling 1,0,0,1,…: no beat lost or duplicated; m_octet stable while m_valid && !m_ready.
- rx_payload_length=100: exactly 64 beats, last at address 63, pkt_truncated=1; no wrap to address 0.
- Second rx_decode_end 4 cycles after the first, with length 5: drop_cnt=1 and the first stream completes intact. rx_decode_run pulse mid-stream gives pkt_overrun=1.
- DROP_BAD_CRC=1, rx_crc_ok=0: zero beats, busy stays 0, drop_cnt increments; 260 such packets leave drop_cnt=255.
- rst=0 during beat 3 of a 7-beat packet: next cycle m_valid=0, busy=0, drop_cnt=0. A new rx_decode_end then streams from address 0. With BTLE_RX_PDU_STATUS_BEAT_EN, crc_ok=1, phase=5, no truncation or overrun: 8th beat = 0x85 with m_last=1.

Source files
------------

// File: rtl/btle_rx_pdu_reader_if.sv
// Octet stream from the PDU reader toward the link-layer/host side.
// The master drives data/valid/last; the slave returns ready.
interface btle_rx_pdu_reader_if;
    logic [7:0] m_octet;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    modport master (output m_octet, output m_valid, output m_last, input m_ready);
    modport slave  (input m_octet, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/btle_rx_pdu_reader.sv
// PDU memory reader: on each rx_decode_end it walks the received PDU octet
// memory from address 0 and streams header + payload octets, latching the
// per-packet status (CRC, best phase, truncation, overrun) and counting
// packets that had to be discarded.
// Optional macro BTLE_RX_PDU_STATUS_BEAT_EN: append one status beat
// {crc_ok, truncated, overrun, 2'b00, best_phase} after the last octet.
module btle_rx_pdu_reader #(
    parameter int MEM_ADDR_BIT_WIDTH = 6,
    parameter bit DROP_BAD_CRC       = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_decode_end,
    input  logic                          rx_decode_run,
    input  logic                          rx_crc_ok,
    input  logic [2:0]                    rx_best_phase,
    input  logic [6:0]                    rx_payload_length,
    output logic [MEM_ADDR_BIT_WIDTH-1:0] pdu_octet_mem_addr,
    input  logic [7:0]                    pdu_octet_mem_data,
    btle_rx_pdu_reader_if.master          m_if,
    output logic                          pkt_crc_ok,
    output logic [2:0]                    pkt_best_phase,
    output logic                          pkt_truncated,
    output logic                          pkt_overrun,
    output logic                          busy,
    output logic [7:0]                    drop_cnt
);
    localparam int MEM_DEPTH = 2 ** MEM_ADDR_BIT_WIDTH;
    typedef logic [MEM_ADDR_BIT_WIDTH-1:0] addr_t;

`ifdef BTLE_RX_PDU_STATUS_BEAT_EN
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, STATUS} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, SEND} state_t;
`endif

    state_t     state_q, state_d;
    addr_t      addr_q, addr_d;
    addr_t      last_addr_q, last_addr_d;
    logic [7:0] octet_q, octet_d;
    logic       last_q, last_d;
    logic       crc_ok_q, crc_ok_d;
    logic [2:0] phase_q, phase_d;
    logic       trunc_q, trunc_d;
    logic       overrun_q, overrun_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [7:0] total;
    logic       is_final;
    logic       drop_evt;
    logic       valid_w;

    // Next-state logic, length clamping and drop/overrun bookkeeping.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        octet_d     = octet_q;
        last_d      = last_q;
        crc_ok_d    = crc_ok_q;
        phase_d     = phase_q;
        trunc_d     = trunc_q;
        overrun_d   = overrun_q;
        drop_cnt_d  = drop_cnt_q;
        total       = {1'b0, rx_payload_length} + 8'd2;
        is_final    = (addr_q == last_addr_q);
        drop_evt    = 1'b0;

        // A packet arriving while we are still reading is lost; a receiver
        // write while we read means the octets we stream may be corrupt.
        if (state_q != IDLE) begin
            if (rx_decode_run) overrun_d = 1'b1;
            if (rx_decode_end) drop_evt  = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (rx_decode_end) begin
                    crc_ok_d  = rx_crc_ok;
                    phase_d   = rx_best_phase;
                    overrun_d = 1'b0;
                    addr_d    = '0;
                    if (int'(total) > MEM_DEPTH) begin
                        trunc_d     = 1'b1;
                        last_addr_d = addr_t'(MEM_DEPTH - 1);
                    end else begin
                        trunc_d     = 1'b0;
                        last_addr_d = addr_t'(total - 8'd1);
                    end
                    if (DROP_BAD_CRC && !rx_crc_ok) drop_evt = 1'b1;
                    else                            state_d  = FETCH;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                // Memory data is valid now, one cycle after the address.
                octet_d = pdu_octet_mem_data;
`ifdef BTLE_RX_PDU_STATUS_BEAT_EN
                last_d  = 1'b0;
`else
                last_d  = is_final;
`endif
                state_d = SEND;
            end
            SEND: begin
                if (m_if.m_ready) begin
                    if (!is_final) begin
                        addr_d  = addr_q + addr_t'(1);
                        state_d = FETCH;
                    end else begin
`ifdef BTLE_RX_PDU_STATUS_BEAT_EN
                        octet_d = {crc_ok_q, trunc_q, overrun_q, 2'b00, phase_q};
                        last_d  = 1'b1;
                        state_d = STATUS;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef BTLE_RX_PDU_STATUS_BEAT_EN
            STATUS: if (m_if.m_ready) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        if (drop_evt && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            octet_q     <= '0;
            last_q      <= 1'b0;
            crc_ok_q    <= 1'b0;
            phase_q     <= '0;
            trunc_q     <= 1'b0;
            overrun_q   <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            octet_q     <= octet_d;
            last_q      <= last_d;
            crc_ok_q    <= crc_ok_d;
            phase_q     <= phase_d;
            trunc_q     <= trunc_d;
            overrun_q   <= overrun_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

`ifdef BTLE_RX_PDU_STATUS_BEAT_EN
    assign valid_w = (state_q == SEND) || (state_q == STATUS);
`else
    assign valid_w = (state_q == SEND);
`endif

    assign pdu_octet_mem_addr = addr_q;
    assign m_if.m_octet       = octet_q;
    assign m_if.m_valid       = valid_w;
    assign m_if.m_last        = last_q & valid_w;
    assign pkt_crc_ok         = crc_ok_q;
    assign pkt_best_phase     = phase_q;
    assign pkt_truncated      = trunc_q;
    assign pkt_overrun        = overrun_q;
    assign busy               = (state_q != IDLE);
    assign drop_cnt           = drop_cnt_q;
endmodule
